// File: rtl/rom_matrix_loader.sv
// rom_matrix_loader
//   Takes the read controller's enable/address stream and delays it to line up
//   with the coefficient ROM's read latency. It captures the eight ROM words as
//   two 2x2 matrices and hands each complete matrix to the inverse core over a
//   valid/ready handshake.
//
// Parameters
//   DATA_W       width of one ROM word / matrix element
//   ROM_LATENCY  cycles from I_rom_ena/I_rom_addr to valid I_rom_data (1..4)
//
// Ports
//   I_sys_clk, I_sys_rst   clock (rising edge) and async active-high reset
//   I_rom_ena, I_rom_addr  enable/address from the read controller
//   I_rom_data             ROM output word
//   I_mat_ready            inverse core accepts the presented matrix
//   O_mat_valid, O_mat_id  matrix present / matrix index (addr[2])
//   O_mat_a..O_mat_d       elements at slots 0..3, row-major
//   O_seq_err              one-cycle pulse on an out-of-order slot
//   O_overflow             sticky: a completed matrix was dropped
//
// Optional build macro ROM_MATRIX_LOADER_DET_EN adds the following outputs:
//   O_det       signed a*d - b*c, 2*DATA_W+1 bits
//   O_singular  O_det == 0
module rom_matrix_loader #(
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst,
  input  logic              I_rom_ena,
  input  logic [2:0]        I_rom_addr,
  input  logic [DATA_W-1:0] I_rom_data,
  input  logic              I_mat_ready,
  output logic              O_mat_valid,
  output logic              O_mat_id,
  output logic [DATA_W-1:0] O_mat_a,
  output logic [DATA_W-1:0] O_mat_b,
  output logic [DATA_W-1:0] O_mat_c,
  output logic [DATA_W-1:0] O_mat_d,
  output logic              O_seq_err,
`ifdef ROM_MATRIX_LOADER_DET_EN
  output logic signed [2*DATA_W:0] O_det,
  output logic              O_singular,
`endif
  output logic              O_overflow
);

  // state | meaning
  // IDLE  | waiting for a slot-0 word to start a matrix
  // FILL  | slots 0..expect-1 captured, waiting for slot expect
  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [ROM_LATENCY-1:0]      ena_pipe_q, ena_pipe_d;
  logic [ROM_LATENCY-1:0][2:0] addr_pipe_q, addr_pipe_d;

  logic [1:0]        expect_q, expect_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d, buf_c_q, buf_c_d;

  logic              valid_q, valid_d, mat_id_q, mat_id_d;
  logic [DATA_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [DATA_W-1:0] mat_c_q, mat_c_d, mat_d_q, mat_d_d;
  logic              seq_err_q, seq_err_d, overflow_q, overflow_d;

  logic       ena_d, addr_hi;
  logic [2:0] addr_d;
  logic [1:0] slot;
  logic       in_order, start, store, complete, err, load;

  assign ena_d   = ena_pipe_q[ROM_LATENCY-1];
  assign addr_d  = addr_pipe_q[ROM_LATENCY-1];
  assign slot    = addr_d[1:0];
  assign addr_hi = addr_d[2];
  assign in_order = (slot == expect_q) && (addr_hi == id_q);

  always_comb begin
    ena_pipe_d     = ena_pipe_q;
    addr_pipe_d    = addr_pipe_q;
    ena_pipe_d[0]  = I_rom_ena;
    addr_pipe_d[0] = I_rom_addr;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      ena_pipe_d[i]  = ena_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ena_d) begin
      case (state_q)
        S_IDLE: if (slot == 2'd0) state_d = S_FILL;
        S_FILL: begin
          if (slot == 2'd0)  state_d = S_FILL;
          else if (in_order) state_d = (slot == 2'd3) ? S_IDLE : S_FILL;
          else               state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start    = 1'b0;
    store    = 1'b0;
    complete = 1'b0;
    err      = 1'b0;
    if (ena_d) begin
      case (state_q)
        S_IDLE: begin
          if (slot == 2'd0) start = 1'b1;
          else              err   = 1'b1;
        end
        S_FILL: begin
          if (slot == 2'd0) begin
            start = 1'b1;
            err   = 1'b1;
          end else if (in_order) begin
            store    = 1'b1;
            complete = (slot == 2'd3);
          end else begin
            err = 1'b1;
          end
        end
        default: err = 1'b0;
      endcase
    end
  end

  // Slot 3 is never buffered: it comes straight from I_rom_data into the output
  // register, so the matrix leaves one edge after its last word is present.
  always_comb begin
    expect_d = expect_q;
    id_d     = id_q;
    buf_a_d  = buf_a_q;
    buf_b_d  = buf_b_q;
    buf_c_d  = buf_c_q;
    if (start) begin
      buf_a_d  = I_rom_data;
      id_d     = addr_hi;
      expect_d = 2'd1;
    end else if (store) begin
      case (slot)
        2'd1:    buf_b_d = I_rom_data;
        2'd2:    buf_c_d = I_rom_data;
        default: buf_a_d = buf_a_q;
      endcase
      expect_d = expect_q + 2'd1;
    end
  end

  assign load = complete && (!valid_q || I_mat_ready);

  always_comb begin
    valid_d    = valid_q;
    mat_id_d   = mat_id_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    mat_c_d    = mat_c_q;
    mat_d_d    = mat_d_q;
    seq_err_d  = err;
    overflow_d = overflow_q | (complete && valid_q && !I_mat_ready);
    if (load) begin
      valid_d  = 1'b1;
      mat_id_d = id_q;
      mat_a_d  = buf_a_q;
      mat_b_d  = buf_b_q;
      mat_c_d  = buf_c_q;
      mat_d_d  = I_rom_data;
    end else if (valid_q && I_mat_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      ena_pipe_q  <= '0;
      addr_pipe_q <= '0;
      expect_q    <= '0;
      id_q        <= 1'b0;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      buf_c_q     <= '0;
      valid_q     <= 1'b0;
      mat_id_q    <= 1'b0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      mat_c_q     <= '0;
      mat_d_q     <= '0;
      seq_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ena_pipe_q  <= ena_pipe_d;
      addr_pipe_q <= addr_pipe_d;
      expect_q    <= expect_d;
      id_q        <= id_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      buf_c_q     <= buf_c_d;
      valid_q     <= valid_d;
      mat_id_q    <= mat_id_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      mat_c_q     <= mat_c_d;
      mat_d_q     <= mat_d_d;
      seq_err_q   <= seq_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign O_mat_valid = valid_q;
  assign O_mat_id    = mat_id_q;
  assign O_mat_a     = mat_a_q;
  assign O_mat_b     = mat_b_q;
  assign O_mat_c     = mat_c_q;
  assign O_mat_d     = mat_d_q;
  assign O_seq_err   = seq_err_q;
  assign O_overflow  = overflow_q;

`ifdef ROM_MATRIX_LOADER_DET_EN
  // Operands are sign-extended to the full result width first; the exact
  // determinant of two signed DATA_W products always fits in 2*DATA_W+1 bits.
  logic signed [2*DATA_W:0] ext_a, ext_b, ext_c, ext_d;
  logic signed [2*DATA_W:0] det_q, det_d, det_new;
  logic                     singular_q, singular_d;

  assign ext_a   = {{(DATA_W+1){buf_a_q[DATA_W-1]}}, buf_a_q};
  assign ext_b   = {{(DATA_W+1){buf_b_q[DATA_W-1]}}, buf_b_q};
  assign ext_c   = {{(DATA_W+1){buf_c_q[DATA_W-1]}}, buf_c_q};
  assign ext_d   = {{(DATA_W+1){I_rom_data[DATA_W-1]}}, I_rom_data};
  assign det_new = (ext_a * ext_d) - (ext_b * ext_c);

  always_comb begin
    det_d      = det_q;
    singular_d = singular_q;
    if (load) begin
      det_d      = det_new;
      singular_d = (det_new == '0);
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      det_q      <= '0;
      singular_q <= 1'b0;
    end else begin
      det_q      <= det_d;
      singular_q <= singular_d;
    end
  end

  assign O_det      = det_q;
  assign O_singular = singular_q;
`endif

endmodule

// File: doc/rom_matrix_loader.md
Name: rom_matrix_loader

Overview:
- Downstream consumer of the ROM read controller and the coefficient ROM.
- Aligns the controller's enable/address with ROM read latency and captures 8 ROM words.
- Packs the words into two 2x2 matrices (addr[2] selects the matrix; addr[1:0] selects the element a,b,c,d).
- Hands each complete matrix to the inverse core over a valid/ready handshake.

Parameters:
- DATA_W, 16, width of one ROM word / matrix element
- ROM_LATENCY, 1, clock cycles from I_rom_ena/I_rom_addr to valid I_rom_data; legal range 1..4

Ports:
- I_sys_clk  input  1  system clock, all logic on rising edge
- I_sys_rst  input  1  asynchronous, active-high reset
- I_rom_ena  input  1  ROM enable from the read controller
- I_rom_addr  input  3  ROM address from the read controller
- I_rom_data  input  DATA_W  ROM output word
- I_mat_ready  input  1  inverse core accepts the matrix
- O_mat_valid  output  1  matrix output holds a complete matrix
- O_mat_id  output  1  matrix index (addr[2] of the captured words)
- O_mat_a, O_mat_b, O_mat_c, O_mat_d  output  DATA_W each  elements at slots 0,1,2,3 (row-major)
- O_seq_err  output  1  one-cycle pulse on an out-of-order slot
- O_overflow  output  1  sticky: a completed matrix was dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While I_sys_rst is high:
  - all outputs are 0;
  - the alignment pipeline, capture buffer and FSM are cleared.
  - Reset asserted mid-fill discards the partial matrix. The next matrix needs a fresh slot 0.
- Alignment: I_rom_ena and I_rom_addr pass through a ROM_LATENCY-deep shift register, giving ena_d and addr_d.
  - A word is captured when ena_d=1, from I_rom_data at that cycle.
- Capture FSM, states IDLE, FILL:
  - IDLE: on ena_d with slot=addr_d[1:0]=0, store the word into buf_a, latch id=addr_d[2], go to FILL with expect=1.
  - IDLE: on ena_d with slot!=0, pulse O_seq_err and stay in IDLE.
  - FILL: on ena_d with slot==expect and addr_d[2]==id, store the word into the slot and increment expect.
  - FILL: on ena_d with slot==0, restart as in IDLE and pulse O_seq_err (the partial matrix is lost).
  - FILL: any other ena_d pulses O_seq_err, discards the buffer and goes to IDLE.
  - FILL: storing slot 3 completes the matrix and returns the FSM to IDLE in the same cycle.
  - FILL: cycles with ena_d=0 keep the state; there is no timeout.
- Output register and handshake:
  - On completion, if O_mat_valid=0, or O_mat_valid=1 with I_mat_ready=1 in the same cycle, load O_mat_a..d and O_mat_id on the next edge and set O_mat_valid=1.
  - On completion with O_mat_valid=1 and I_mat_ready=0: drop the new matrix, set O_overflow=1 (cleared only by reset) and leave the output unchanged.
  - Transfer occurs when O_mat_valid and I_mat_ready are both 1. With no new completion, O_mat_valid clears on the next edge.
  - While O_mat_valid=1 and not accepted, the data and id outputs are stable.
- Latency: slot-3 word sampled at edge N gives O_mat_valid=1 after edge N+1. Total latency is ROM_LATENCY+1 cycles from the controller's slot-3 address to O_mat_valid.
- Widths: the expect counter is 2 bits. The last valid value written is 3; completion is detected before wrap.
- Nominal stream from the controller: addr 0..7 back-to-back yields matrix 0 then matrix 1. Matrix 1 completes 4 cycles after matrix 0, so the core must accept within 4 cycles or matrix 1 is dropped.

Optional Feature:
- Macro ROM_MATRIX_LOADER_DET_EN.
- Defined:
  - extra output O_det, 2*DATA_W+1 bits, signed: a*d - b*c, operands treated as signed;
  - extra output O_singular, 1 bit: O_det==0;
  - both are registered together with the matrix and valid under the same rules as O_mat_*.
  - 0 at reset.
- Undefined: the ports and arithmetic do not exist; the block behaves as above.

Test Plan:
- Addresses 0..7 back-to-back, ROM data = 0x0010+addr, I_mat_ready=1:
  - id 0 valid with a..d = 0x10,0x11,0x12,0x13;
  - 4 cycles later, id 1 with 0x14..0x17;
  - O_seq_err and O_overflow stay 0.
- Same stream, I_mat_ready=0 throughout: matrix 0 held stable, matrix 1 dropped, O_overflow=1. Raising ready then gives a single transfer, and valid returns to 0.
- ROM_LATENCY=3, same stream: O_mat_valid rises 4 cycles after the controller drives addr 3, with correct data.
- Address sequence 0,1,3: O_seq_err pulses on slot 3, and no valid is produced. A following 4,5,6,7 yields id 1 correctly.
- Assert I_sys_rst after addresses 0,1, then deassert and send 0..3: a single matrix with id 0 and the new data, no error pulse.
- With ROM_MATRIX_LOADER_DET_EN, elements 3,2,6,4: O_det=0 and O_singular=1. Elements 4,7,2,6: O_det=10 and O_singular=0.
